// File: rtl/d_bus_router.sv
// Data-side router: core loads/stores to one synchronous RAM port or NUM_IO
// IO channels, with upgrade-writer arbitration, IO timeout and error tracking.
module d_bus_router #(
    parameter int XLEN         = 32,
    parameter int ADDR_LEN     = 16,
    parameter int RAM_ADDR_LEN = ADDR_LEN - 2,
    parameter int NUM_IO       = 4,
    parameter int IO_SEL_LSB   = 8,
    parameter int IO_SEL_W     = 2,
    parameter int TIMEOUT      = 255,
    parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [ADDR_LEN-1:0]      addr,
    input  logic                     rd_req,
    input  logic                     wr_req,
    input  logic [XLEN/8-1:0]        be,
    input  logic [XLEN-1:0]          wr_data,
    output logic [XLEN-1:0]          rd_data,
    output logic                     rd_ready,
    output logic                     wr_ready,
    input  logic                     upg_wr_en,
    input  logic [RAM_ADDR_LEN-1:0]  upg_addr,
    input  logic [XLEN/8-1:0]        upg_we,
    input  logic [XLEN-1:0]          upg_wr_data,
    output logic                     ram_en,
    output logic [XLEN/8-1:0]        ram_we,
    output logic [RAM_ADDR_LEN-1:0]  ram_addr,
    output logic [XLEN-1:0]          ram_wr_data,
    input  logic [XLEN-1:0]          ram_rd_data,
    output logic [NUM_IO-1:0]        io_rd_req,
    output logic [NUM_IO-1:0]        io_wr_req,
    output logic [ADDR_LEN-1:0]      io_addr,
    output logic [XLEN/8-1:0]        io_be,
    output logic [XLEN-1:0]          io_wr_data,
    input  logic [NUM_IO*XLEN-1:0]   io_rd_data,
    input  logic [NUM_IO-1:0]        io_rd_ready,
    input  logic [NUM_IO-1:0]        io_wr_ready,
    output logic                     bus_err,
    input  logic                     err_clr,
    output logic [7:0]               err_cnt
);

    localparam int BW = XLEN / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, RAM_RD, IO_WAIT, DONE, ERR
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_LEN-1:0]  io_addr_q, io_addr_d;
    logic [BW-1:0]        io_be_q, io_be_d;
    logic [XLEN-1:0]      io_wdata_q, io_wdata_d;
    logic [IO_SEL_W-1:0]  ch_q, ch_d;
    logic                 is_wr_q, is_wr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic                 bus_err_q, bus_err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic                 is_io, dec_err, any_req;
    logic [IO_SEL_W-1:0]  ch;
    logic [NUM_IO-1:0]    sel;
    logic                 sel_ready;
    logic [XLEN-1:0]      sel_rdata;

    assign is_io   = addr[ADDR_LEN-1];
    assign ch      = addr[IO_SEL_LSB +: IO_SEL_W];
    assign dec_err = is_io && ({1'b0, ch} >= (IO_SEL_W + 1)'(NUM_IO));
    assign any_req = rd_req | wr_req;
    assign sel     = NUM_IO'(1) << ch_q;
    assign sel_ready = is_wr_q ? |(io_wr_ready & sel)
                               : |(io_rd_ready & sel);

    // Pick the read-data slice of the latched channel without a variable part-select.
    always_comb begin
        sel_rdata = '0;
        for (int c = 0; c < NUM_IO; c++) begin
            if (ch_q == IO_SEL_W'(c)) sel_rdata = io_rd_data[c*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= IDLE;
            io_addr_q  <= '0;
            io_be_q    <= '0;
            io_wdata_q <= '0;
            ch_q       <= '0;
            is_wr_q    <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            io_addr_q  <= io_addr_d;
            io_be_q    <= io_be_d;
            io_wdata_q <= io_wdata_d;
            ch_q       <= ch_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        io_addr_d  = io_addr_q;
        io_be_d    = io_be_q;
        io_wdata_d = io_wdata_q;
        ch_d       = ch_q;
        is_wr_d    = is_wr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        bus_err_d  = bus_err_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req && !is_io) begin
                    if (!wr_req && !upg_wr_en) state_d = RAM_RD;
                end else if (any_req) begin
                    is_wr_d = wr_req;
                    if (dec_err) begin
                        state_d = ERR;
                    end else begin
                        io_addr_d  = addr;
                        io_be_d    = be;
                        io_wdata_d = wr_data;
                        ch_d       = ch;
                        cnt_d      = '0;
                        state_d    = IO_WAIT;
                    end
                end
            end
            RAM_RD: state_d = IDLE;
            IO_WAIT: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A clear in the same cycle as an error wins over the increment.
        if (err_clr) begin
            bus_err_d = 1'b0;
            err_cnt_d = '0;
        end else if (state_q == ERR) begin
            bus_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_comb begin
        rd_data     = '0;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        ram_en      = 1'b0;
        ram_we      = '0;
        ram_addr    = '0;
        ram_wr_data = '0;
        io_rd_req   = '0;
        io_wr_req   = '0;
        if (rstb) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req && !is_io && !upg_wr_en) begin
                        ram_en   = 1'b1;
                        ram_addr = addr[RAM_ADDR_LEN+1:2];
                        if (wr_req) begin
                            ram_we      = be;
                            ram_wr_data = wr_data;
                            wr_ready    = 1'b1;
                        end
                    end
                end
                RAM_RD: begin
                    rd_ready = 1'b1;
                    rd_data  = ram_rd_data;
                end
                IO_WAIT: begin
                    if (is_wr_q) io_wr_req = sel;
                    else         io_rd_req = sel;
                end
                DONE: begin
                    wr_ready = is_wr_q;
                    rd_ready = !is_wr_q;
                    if (!is_wr_q) rd_data = rdata_q;
                end
                ERR: begin
                    wr_ready = is_wr_q;
                    rd_ready = !is_wr_q;
                    if (!is_wr_q) rd_data = ERR_DATA;
                end
                default: ;
            endcase
            if (upg_wr_en) begin
                ram_en      = 1'b1;
                ram_we      = upg_we;
                ram_addr    = upg_addr;
                ram_wr_data = upg_wr_data;
            end
        end
    end

    assign io_addr    = io_addr_q;
    assign io_be      = io_be_q;
    assign io_wr_data = io_wdata_q;
    assign bus_err    = bus_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_d_bus_router.sv
// Directed bench for d_bus_router: RAM path, upgrade arbitration, IO wait,
// timeout, decode errors with counter saturation/clear, and reset mid-access.
module tb_d_bus_router;

    localparam int XLEN = 32;
    localparam int NIO  = 3;

    logic             clk = 1'b0;
    logic             rstb;
    logic [15:0]      addr;
    logic             rd_req, wr_req;
    logic [3:0]       be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;
    logic             rd_ready, wr_ready;
    logic             upg_wr_en;
    logic [13:0]      upg_addr;
    logic [3:0]       upg_we;
    logic [31:0]      upg_wr_data;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic [13:0]      ram_addr;
    logic [31:0]      ram_wr_data;
    logic [31:0]      ram_rd_data;
    logic [NIO-1:0]   io_rd_req, io_wr_req;
    logic [15:0]      io_addr;
    logic [3:0]       io_be;
    logic [31:0]      io_wr_data;
    logic [NIO*32-1:0] io_rd_data;
    logic [NIO-1:0]   io_rd_ready, io_wr_ready;
    logic             bus_err;
    logic             err_clr;
    logic [7:0]       err_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    d_bus_router #(.NUM_IO(NIO)) dut (
        .clk(clk), .rstb(rstb), .addr(addr),
        .rd_req(rd_req), .wr_req(wr_req), .be(be), .wr_data(wr_data),
        .rd_data(rd_data), .rd_ready(rd_ready), .wr_ready(wr_ready),
        .upg_wr_en(upg_wr_en), .upg_addr(upg_addr), .upg_we(upg_we),
        .upg_wr_data(upg_wr_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .io_rd_req(io_rd_req), .io_wr_req(io_wr_req), .io_addr(io_addr),
        .io_be(io_be), .io_wr_data(io_wr_data), .io_rd_data(io_rd_data),
        .io_rd_ready(io_rd_ready), .io_wr_ready(io_wr_ready),
        .bus_err(bus_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM with byte writes.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rd_data <= mem[ram_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        wr_req = 1'b1;
        addr = 16'h0010;
        tick(); tick();
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready got %b exp 0", rd_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b exp 0", ram_en); end
        checks++; if ({io_rd_req, io_wr_req} !== '0) begin errors++; $display("FAIL rst_io_req got %b%b exp 0", io_rd_req, io_wr_req); end
        checks++; if ({bus_err, err_cnt} !== 9'd0) begin errors++; $display("FAIL rst_err got %b/%0d exp 0/0", bus_err, err_cnt); end
        checks++; if ({rd_data, io_addr, io_wr_data} !== '0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", rd_data, io_addr, io_wr_data); end
        wr_req = 1'b0;
        rstb = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        wr_req = 1'b1; addr = 16'h0010; be = 4'b0011; wr_data = 32'h1234_5678;
        #2;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ram_wr_ready got %b exp 1", wr_ready); end
        checks++; if ({ram_en, ram_addr, ram_we} !== {1'b1, 14'd4, 4'b0011}) begin errors++; $display("FAIL ram_wr_port got en=%b a=%0d we=%b exp 1/4/0011", ram_en, ram_addr, ram_we); end
        checks++; if (ram_wr_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_wr_data got %h exp 12345678", ram_wr_data); end
        tick();
        wr_req = 1'b0; rd_req = 1'b1; be = 4'hF;
        #2;
        checks++; if ({rd_ready, ram_en, ram_we} !== {1'b0, 1'b1, 4'b0}) begin errors++; $display("FAIL ram_rd_issue got rdy=%b en=%b we=%b exp 0/1/0", rd_ready, ram_en, ram_we); end
        tick();
        #2;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL ram_rd_ready got %b exp 1", rd_ready); end
        checks++; if (rd_data !== 32'h0000_5678) begin errors++; $display("FAIL ram_rd_data got %h exp 00005678", rd_data); end
        tick();
        rd_req = 1'b0;
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL ram_rd_pulse got %b exp 0", rd_ready); end
        tick();
    endtask

    task automatic test_upgrade();
        upg_wr_en = 1'b1; upg_addr = 14'd9; upg_we = 4'hF; upg_wr_data = 32'hCAFE_F00D;
        rd_req = 1'b1; addr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({ram_en, ram_addr, ram_we} !== {1'b1, 14'd9, 4'hF}) begin errors++; $display("FAIL upg_port[%0d] got en=%b a=%0d we=%b exp 1/9/1111", i, ram_en, ram_addr, ram_we); end
            checks++; if ({rd_ready, ram_wr_data} !== {1'b0, 32'hCAFE_F00D}) begin errors++; $display("FAIL upg_data[%0d] got rdy=%b d=%h exp 0/cafef00d", i, rd_ready, ram_wr_data); end
            tick();
        end
        upg_wr_en = 1'b0;
        #2;
        checks++; if ({rd_ready, ram_en, ram_addr, ram_we} !== {1'b0, 1'b1, 14'd4, 4'b0}) begin errors++; $display("FAIL upg_release got rdy=%b en=%b a=%0d we=%b exp 0/1/4/0", rd_ready, ram_en, ram_addr, ram_we); end
        tick();
        #2;
        checks++; if ({rd_ready, rd_data} !== {1'b1, 32'h0000_5678}) begin errors++; $display("FAIL upg_rd got rdy=%b d=%h exp 1/00005678", rd_ready, rd_data); end
        checks++; if (mem[9] !== 32'hCAFE_F00D) begin errors++; $display("FAIL upg_mem got %h exp cafef00d", mem[9]); end
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_io_read();
        int n = 0;
        rd_req = 1'b1; addr = 16'h8100; be = 4'hF;
        io_rd_data = '0;
        #2;
        checks++; if (io_rd_req !== 3'b000) begin errors++; $display("FAIL ior_idle got %b exp 000", io_rd_req); end
        tick();
        for (int i = 1; i <= 5; i++) begin
            io_rd_ready = (i == 5) ? 3'b010 : 3'b001;
            io_rd_data[0 +: 32]  = 32'hBAD0_0000;
            io_rd_data[32 +: 32] = (i == 5) ? 32'h0000_00A5 : 32'h0000_0011;
            #2;
            if (io_rd_req === 3'b010 && rd_ready === 1'b0) n++;
            tick();
        end
        io_rd_ready = '0;
        checks++; if (n !== 5) begin errors++; $display("FAIL ior_req_cycles got %0d exp 5", n); end
        checks++; if (io_addr !== 16'h8100) begin errors++; $display("FAIL ior_addr got %h exp 8100", io_addr); end
        #2;
        checks++; if ({rd_ready, rd_data, io_rd_req} !== {1'b1, 32'hA5, 3'b0}) begin errors++; $display("FAIL ior_done got rdy=%b d=%h req=%b exp 1/a5/000", rd_ready, rd_data, io_rd_req); end
        tick();
        rd_req = 1'b0;
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL ior_pulse got %b exp 0", rd_ready); end
        tick();
    endtask

    task automatic test_io_timeout();
        int n = 0;
        wr_req = 1'b1; addr = 16'h8200; be = 4'b1010; wr_data = 32'h0000_0055;
        tick();
        for (int i = 0; i < 255; i++) begin
            #2;
            if (io_wr_req === 3'b100 && wr_ready === 1'b0) n++;
            tick();
        end
        checks++; if (n !== 255) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 255", n); end
        checks++; if ({io_wr_data, io_be} !== {32'h55, 4'b1010}) begin errors++; $display("FAIL tmo_latch got %h/%b exp 55/1010", io_wr_data, io_be); end
        #2;
        checks++; if ({wr_ready, io_wr_req} !== {1'b1, 3'b0}) begin errors++; $display("FAIL tmo_err got rdy=%b req=%b exp 1/000", wr_ready, io_wr_req); end
        tick();
        wr_req = 1'b0;
        #2;
        checks++; if ({bus_err, err_cnt, wr_ready} !== {1'b1, 8'd1, 1'b0}) begin errors++; $display("FAIL tmo_cnt got err=%b cnt=%0d rdy=%b exp 1/1/0", bus_err, err_cnt, wr_ready); end
        tick();
    endtask

    task automatic test_dec_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_req = 1'b1; addr = 16'h8300;
        #2;
        checks++; if ({io_rd_req, io_wr_req, bus_err} !== 7'b0) begin errors++; $display("FAIL dec_clr got %b %b %b exp 0", io_rd_req, io_wr_req, bus_err); end
        tick();
        #2;
        checks++; if ({rd_ready, rd_data, io_rd_req} !== {1'b1, 32'hDEAD_BEEF, 3'b0}) begin errors++; $display("FAIL dec_rd got rdy=%b d=%h req=%b exp 1/deadbeef/000", rd_ready, rd_data, io_rd_req); end
        tick();
        rd_req = 1'b0;
        #2;
        checks++; if ({bus_err, err_cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL dec_cnt1 got %b/%0d exp 1/1", bus_err, err_cnt); end
        tick();
        for (int i = 0; i < 259; i++) begin
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
            tick();
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL dec_sat got %0d exp 255", err_cnt); end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if ({bus_err, err_cnt} !== 9'd0) begin errors++; $display("FAIL dec_clr_wins got %b/%0d exp 0/0", bus_err, err_cnt); end
    endtask

    task automatic test_reset_mid_io();
        rd_req = 1'b1; addr = 16'h8000;
        tick(); tick();
        checks++; if (io_rd_req !== 3'b001) begin errors++; $display("FAIL rio_req got %b exp 001", io_rd_req); end
        rstb = 1'b0; rd_req = 1'b0;
        tick();
        rstb = 1'b1;
        io_rd_ready = 3'b001;
        #2;
        checks++; if ({io_rd_req, rd_ready, io_addr} !== '0) begin errors++; $display("FAIL rio_drop got req=%b rdy=%b a=%h exp 0", io_rd_req, rd_ready, io_addr); end
        tick();
        io_rd_ready = '0;
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rio_no_pulse got %b exp 0", rd_ready); end
        wr_req = 1'b1; addr = 16'h8004; wr_data = 32'h0000_0077;
        tick();
        io_wr_ready = 3'b001;
        #2;
        checks++; if ({io_wr_req, io_addr} !== {3'b001, 16'h8004}) begin errors++; $display("FAIL rio_after got %b/%h exp 001/8004", io_wr_req, io_addr); end
        tick();
        io_wr_ready = '0;
        #2;
        checks++; if ({wr_ready, io_wr_req} !== {1'b1, 3'b0}) begin errors++; $display("FAIL rio_done got %b/%b exp 1/000", wr_ready, io_wr_req); end
        tick();
        wr_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rd_data = '0;
        rstb = 1'b0; addr = '0; rd_req = 1'b0; wr_req = 1'b0;
        be = '0; wr_data = '0; upg_wr_en = 1'b0; upg_addr = '0;
        upg_we = '0; upg_wr_data = '0; io_rd_data = '0;
        io_rd_ready = '0; io_wr_ready = '0; err_clr = 1'b0;
        test_reset();
        test_ram();
        test_upgrade();
        test_io_read();
        test_io_timeout();
        test_dec_err();
        test_reset_mid_io();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
